tia_horizontal_sync_ctl: RTL and testbench

//  Sequences the TIA horizontal line, driven by the biphase clock (phi1/phi2 = one pulse each per 4 clk).

---
 rtl/tia_horizontal_sync_ctl_pkg.sv | 24 ++
 rtl/tia_wsync_ready.sv | 43 ++++
 rtl/tia_horizontal_sync_ctl.sv | 128 ++++++++++++
 tb/tb_tia_horizontal_sync_ctl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_horizontal_sync_ctl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tia_horizontal_sync_ctl_pkg
// Brief    : Horizontal-line decode points and WSYNC FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package tia_horizontal_sync_ctl_pkg;

    localparam int unsigned c_HC_W = 6;

    localparam logic [c_HC_W-1:0] c_HC_MAX       = 6'd56;
    localparam logic [c_HC_W-1:0] c_HSYNC_SET    = 6'd4;
    localparam logic [c_HC_W-1:0] c_HSYNC_CLR    = 6'd8;
    localparam logic [c_HC_W-1:0] c_CB_SET       = 6'd8;
    localparam logic [c_HC_W-1:0] c_CB_CLR       = 6'd12;
    localparam logic [c_HC_W-1:0] c_HB_CLR       = 6'd17;
    localparam logic [c_HC_W-1:0] c_HB_CLR_HMOVE = 6'd19;

    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_HALT = 1'b1;

endpackage : tia_horizontal_sync_ctl_pkg
`default_nettype wire

// File: rtl/tia_wsync_ready.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tia_wsync_ready
// Brief    : RUN/HALT handshake that holds the CPU off from WSYNC until the
//            next natural line wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tia_wsync_ready
    import tia_horizontal_sync_ctl_pkg::*;
(
    input  logic clk,
    input  logic resetl,
    input  logic wsync_strobe,
    input  logic line_start,
    output logic rdy
);

    logic [0:0] r_state;
    logic [0:0] w_state_next;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A strobe coinciding with the wrap halts; only the following wrap releases.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:  if (wsync_strobe) w_state_next = c_ST_HALT;
            c_ST_HALT: if (line_start)   w_state_next = c_ST_RUN;
            default:   w_state_next = c_ST_RUN;
        endcase
    end

    assign rdy = (r_state == c_ST_RUN);

endmodule : tia_wsync_ready
`default_nettype wire

// File: rtl/tia_horizontal_sync_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tia_horizontal_sync_ctl
// Brief    : TIA horizontal line sequencer: phi2-driven line counter, HSYNC /
//            HBLANK / colour-burst decode, RSYNC, WSYNC and HMOVE strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tia_horizontal_sync_ctl
    import tia_horizontal_sync_ctl_pkg::*;
#(
    parameter logic [c_HC_W-1:0] HC_MAX       = c_HC_MAX,
    parameter logic [c_HC_W-1:0] HSYNC_SET    = c_HSYNC_SET,
    parameter logic [c_HC_W-1:0] HSYNC_CLR    = c_HSYNC_CLR,
    parameter logic [c_HC_W-1:0] CB_SET       = c_CB_SET,
    parameter logic [c_HC_W-1:0] CB_CLR       = c_CB_CLR,
    parameter logic [c_HC_W-1:0] HB_CLR       = c_HB_CLR,
    parameter logic [c_HC_W-1:0] HB_CLR_HMOVE = c_HB_CLR_HMOVE
)(
    input  logic              clk,
    input  logic              resetl,
    input  logic              phi1,
    input  logic              phi2,
    input  logic              rsync_strobe,
    input  logic              wsync_strobe,
    input  logic              hmove_strobe,
    output logic              bpc_r,
    output logic [c_HC_W-1:0] hcount,
    output logic              line_start,
    output logic              hsync,
    output logic              hblank,
    output logic              cburst,
    output logic              rdy,
    output logic              phase_err
);

    logic [c_HC_W-1:0] r_hcount;
    logic              r_bpc_r;
    logic              r_line_start;
    logic              r_hsync;
    logic              r_hblank;
    logic              r_cburst;
    logic              r_phase_err;
    logic              r_hmove_latch;

    logic              w_adv;
    logic              w_wrap;
    logic [c_HC_W-1:0] w_hc_next;
    logic [c_HC_W-1:0] w_hb_clr;

    // RSYNC owns the cycle it lands in, so a coincident phi2 is dropped.
    assign w_adv     = phi2 & ~rsync_strobe;
    assign w_wrap    = w_adv & (r_hcount == HC_MAX);
    assign w_hc_next = w_wrap ? '0 : r_hcount + 6'd1;
    assign w_hb_clr  = r_hmove_latch ? HB_CLR_HMOVE : HB_CLR;

    always_ff @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            r_hcount      <= '0;
            r_bpc_r       <= 1'b1;
            r_line_start  <= 1'b0;
            r_hsync       <= 1'b0;
            r_hblank      <= 1'b1;
            r_cburst      <= 1'b0;
            r_phase_err   <= 1'b0;
            r_hmove_latch <= 1'b0;
        end else begin
            r_bpc_r      <= rsync_strobe;
            r_line_start <= w_wrap;

            if (phi1 & phi2) begin
                r_phase_err <= 1'b1;
            end

            if (rsync_strobe) begin
                r_hcount <= '0;
                r_hblank <= 1'b1;
                r_hsync  <= 1'b0;
                r_cburst <= 1'b0;
            end else if (w_adv) begin
                r_hcount <= w_hc_next;

                if (w_hc_next == HSYNC_SET) begin
                    r_hsync <= 1'b1;
                end else if (w_hc_next == HSYNC_CLR) begin
                    r_hsync <= 1'b0;
                end

                if (w_hc_next == CB_SET) begin
                    r_cburst <= 1'b1;
                end else if (w_hc_next == CB_CLR) begin
                    r_cburst <= 1'b0;
                end

                if (w_wrap) begin
                    r_hblank <= 1'b1;
                end else if (w_hc_next == w_hb_clr) begin
                    r_hblank <= 1'b0;
                end
            end

            // A strobe arriving with the wrap belongs to the ending line.
            if (w_wrap) begin
                r_hmove_latch <= 1'b0;
            end else if (hmove_strobe) begin
                r_hmove_latch <= 1'b1;
            end
        end
    end

    tia_wsync_ready u_wsync_ready (
        .clk          (clk),
        .resetl       (resetl),
        .wsync_strobe (wsync_strobe),
        .line_start   (w_wrap),
        .rdy          (rdy)
    );

    assign hcount     = r_hcount;
    assign bpc_r      = r_bpc_r;
    assign line_start = r_line_start;
    assign hsync      = r_hsync;
    assign hblank     = r_hblank;
    assign cburst     = r_cburst;
    assign phase_err  = r_phase_err;

endmodule : tia_horizontal_sync_ctl
`default_nettype wire

// File: tb/tb_tia_horizontal_sync_ctl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tia_horizontal_sync_ctl
// Brief    : Self-checking bench: line-position reference model against the
//            horizontal sync controller under a biphase clock model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tia_horizontal_sync_ctl;

    logic       clk = 1'b0;
    logic       resetl = 1'b0;
    logic       phi1 = 1'b0;
    logic       phi2 = 1'b0;
    logic       rsync_strobe = 1'b0;
    logic       wsync_strobe = 1'b0;
    logic       hmove_strobe = 1'b0;
    logic       bpc_r, line_start, hsync, hblank, cburst, rdy, phase_err;
    logic [5:0] hcount;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;
    int bp_cnt   = 0;
    bit force_both = 1'b0;

    tia_horizontal_sync_ctl dut (
        .clk          (clk),
        .resetl       (resetl),
        .phi1         (phi1),
        .phi2         (phi2),
        .rsync_strobe (rsync_strobe),
        .wsync_strobe (wsync_strobe),
        .hmove_strobe (hmove_strobe),
        .bpc_r        (bpc_r),
        .hcount       (hcount),
        .line_start   (line_start),
        .hsync        (hsync),
        .hblank       (hblank),
        .cburst       (cburst),
        .rdy          (rdy),
        .phase_err    (phase_err)
    );

    always #100 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Biphase model: phi2 high, low, phi1 high, low.
    initial begin
        forever begin
            @(posedge clk);
            #20;
            bp_cnt = (bp_cnt + 1) % 4;
            phi2 = force_both || (bp_cnt == 0);
            phi1 = force_both || (bp_cnt == 2);
        end
    end

    // Reference model: line position in phi2 ticks plus halt / hmove flags.
    logic [5:0] m_pos;
    logic       m_hm, m_halt, m_bpc, m_ls, m_perr;
    logic       m_adv, m_wrap;
    assign m_adv  = phi2 && !rsync_strobe;
    assign m_wrap = m_adv && (m_pos == 6'd56);

    always @(posedge clk or negedge resetl) begin
        if (!resetl) begin
            m_pos <= 6'd0; m_hm <= 1'b0; m_halt <= 1'b0;
            m_bpc <= 1'b1; m_ls <= 1'b0; m_perr <= 1'b0;
        end else begin
            m_bpc <= rsync_strobe;
            m_ls  <= m_wrap;
            if (phi1 && phi2) m_perr <= 1'b1;
            if (rsync_strobe)  m_pos <= 6'd0;
            else if (m_adv)    m_pos <= m_wrap ? 6'd0 : m_pos + 6'd1;
            if (m_wrap)
                m_hm <= 1'b0;
            else if (hmove_strobe && (m_pos < 6'd16 || (m_pos == 6'd16 && !m_adv)))
                m_hm <= 1'b1;
            if (m_halt) begin
                if (m_wrap) m_halt <= 1'b0;
            end else if (wsync_strobe) begin
                m_halt <= 1'b1;
            end
        end
    end

    logic        e_hsync, e_cburst, e_hblank;
    logic [12:0] act_vec, exp_vec;
    assign e_hsync  = (m_pos >= 6'd4) && (m_pos <= 6'd7);
    assign e_cburst = (m_pos >= 6'd8) && (m_pos <= 6'd11);
    assign e_hblank = m_pos < (m_hm ? 6'd19 : 6'd17);
    assign act_vec  = {bpc_r, hcount, hsync, cburst, hblank, rdy, line_start, phase_err};
    assign exp_vec  = {m_bpc, m_pos, e_hsync, e_cburst, e_hblank, !m_halt, m_ls, m_perr};

    localparam logic [12:0] c_RST_VEC = {1'b1, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // mode 0: any cycle at position p; 1: next edge does not advance; 2: next edge advances
    task automatic wait_pos(input logic [5:0] p, input int mode, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (m_pos == p && (mode == 0 || (mode == 1 && !phi2) || (mode == 2 && phi2))) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit got;
        int c0;
        resetl = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (act_vec !== c_RST_VEC) begin
            n_fails++; $display("FAIL reset_values: got %h expected %h", act_vec, c_RST_VEC);
        end
        resetl = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bpc_r !== 1'b0) begin
            n_fails++; $display("FAIL bpc_release: got %b expected 0", bpc_r);
        end
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fails++; $display("FAIL first_line: got %h expected %h", act_vec, exp_vec);
            end
            if (line_start) begin got = 1'b1; break; end
        end
        c0 = cyc;
        if (got) begin
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                n_checks++;
                if (act_vec !== exp_vec) begin
                    n_fails++; $display("FAIL line_sweep: got %h expected %h", act_vec, exp_vec);
                end
                if (line_start) begin got = 1'b1; break; end
            end
        end
        n_checks++;
        if (!got || (cyc - c0) != 228) begin
            n_fails++; $display("FAIL line_spacing: got %0d clk expected 228", cyc - c0);
        end
    endtask

    task automatic test_free_run();
        int n_hs, n_cb, n_hb;
        bit ok;
        repeat ($urandom_range(0, 50)) @(negedge clk);
        wait_pos(6'd0, 1, ok);
        while (ok && !line_start) @(negedge clk);
        n_hs = 0; n_cb = 0; n_hb = 0;
        for (int i = 0; i < 228; i++) begin
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fails++; $display("FAIL free_run: got %h expected %h", act_vec, exp_vec);
            end
            n_hs += int'(hsync); n_cb += int'(cburst); n_hb += int'(hblank);
            @(negedge clk);
        end
        n_checks++;
        if (!ok || n_hs != 16 || n_cb != 16 || n_hb != 68) begin
            n_fails++;
            $display("FAIL window_widths: got hsync=%0d cburst=%0d hblank=%0d expected 16/16/68", n_hs, n_cb, n_hb);
        end
    endtask

    task automatic test_hmove();
        bit ok;
        int c0;
        logic [5:0] p;
        p = 6'($urandom_range(1, 14));
        for (int ln = 0; ln < 2; ln++) begin
            wait_pos(6'd0, 1, ok);
            while (ok && !line_start) @(negedge clk);
            c0 = cyc;
            if (ln == 0) begin
                wait_pos(p, 1, ok);
                hmove_strobe = 1'b1;
                @(posedge clk); #20 hmove_strobe = 1'b0;
            end
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                n_checks++;
                if (act_vec !== exp_vec) begin
                    n_fails++; $display("FAIL hmove_line: got %h expected %h", act_vec, exp_vec);
                end
                if (!hblank) break;
            end
            n_checks++;
            if (!ok || (cyc - c0) != (ln == 0 ? 76 : 68)) begin
                n_fails++;
                $display("FAIL hmove_blank_len line%0d: got %0d clk expected %0d", ln, cyc - c0, ln == 0 ? 76 : 68);
            end
        end
    endtask

    task automatic test_wsync();
        bit ok, got;
        int c0;
        logic [5:0] p;
        p = 6'($urandom_range(20, 45));
        wait_pos(p, 1, ok);
        wsync_strobe = 1'b1;
        @(posedge clk); #20 wsync_strobe = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!ok || rdy !== 1'b0) begin
            n_fails++; $display("FAIL wsync_halt: got rdy=%b expected 0", rdy);
        end
        wait_pos(p + 6'd3, 1, ok);
        wsync_strobe = 1'b1;
        @(posedge clk); #20 wsync_strobe = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fails++; $display("FAIL wsync_wait: got %h expected %h", act_vec, exp_vec);
            end
            if (line_start) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || rdy !== 1'b1) begin
            n_fails++; $display("FAIL wsync_release: got rdy=%b ls_seen=%b expected 1/1", rdy, got);
        end
        wait_pos(6'd56, 2, ok);
        wsync_strobe = 1'b1;
        @(posedge clk); #20 wsync_strobe = 1'b0;
        @(negedge clk);
        c0 = cyc;
        n_checks++;
        if (!ok || {line_start, rdy} !== 2'b10) begin
            n_fails++; $display("FAIL wsync_on_wrap: got ls/rdy=%b%b expected 10", line_start, rdy);
        end
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rdy === 1'b1) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || (cyc - c0) != 228 || line_start !== 1'b1) begin
            n_fails++; $display("FAIL wsync_wrap_release: got %0d clk ls=%b expected 228 clk ls=1", cyc - c0, line_start);
        end
    endtask

    task automatic test_rsync();
        bit ok, got;
        int ticks;
        logic [5:0] p;
        wait_pos(6'($urandom_range(18, 28)), 1, ok);
        wsync_strobe = 1'b1;
        @(posedge clk); #20 wsync_strobe = 1'b0;
        p = 6'($urandom_range(30, 50));
        wait_pos(p, $urandom_range(1, 2), ok);
        rsync_strobe = 1'b1;
        @(posedge clk); #20 rsync_strobe = 1'b0;
        @(negedge clk);
        n_checks++;
        if (!ok || {hcount, hblank, hsync, cburst, bpc_r, line_start, rdy} !== {6'd0, 5'b10010, 1'b0}) begin
            n_fails++;
            $display("FAIL rsync_effect: got hc=%0d hb=%b hs=%b cb=%b bpc=%b ls=%b rdy=%b expected 0 1 0 0 1 0 0",
                     hcount, hblank, hsync, cburst, bpc_r, line_start, rdy);
        end
        ticks = 0; got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (phi2) ticks++;
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (bpc_r !== 1'b0) begin
                    n_fails++; $display("FAIL rsync_bpc_pulse: got %b expected 0", bpc_r);
                end
            end
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_fails++; $display("FAIL rsync_line: got %h expected %h", act_vec, exp_vec);
            end
            if (line_start) begin got = 1'b1; break; end
        end
        n_checks++;
        if (!got || ticks != 57) begin
            n_fails++; $display("FAIL rsync_next_line: got %0d phi2 ticks expected 57", ticks);
        end
    endtask

    task automatic test_phase_err_async_reset();
        repeat ($urandom_range(10, 60)) @(negedge clk);
        force_both = 1'b1;
        @(posedge clk); #30 force_both = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (phase_err !== 1'b1 || act_vec !== exp_vec) begin
            n_fails++; $display("FAIL phase_err_set: got %h expected %h", act_vec, exp_vec);
        end
        repeat ($urandom_range(20, 40)) @(negedge clk);
        n_checks++;
        if (phase_err !== 1'b1 || act_vec !== exp_vec) begin
            n_fails++; $display("FAIL phase_err_sticky: got %h expected %h", act_vec, exp_vec);
        end
        @(posedge clk);
        #50 resetl = 1'b0;
        #10;
        n_checks++;
        if (act_vec !== c_RST_VEC) begin
            n_fails++; $display("FAIL async_reset: got %h expected %h", act_vec, c_RST_VEC);
        end
        @(negedge clk);
        resetl = 1'b1;
        @(negedge clk);
        n_checks++;
        if (act_vec !== exp_vec) begin
            n_fails++; $display("FAIL after_async_reset: got %h expected %h", act_vec, exp_vec);
        end
    endtask

    initial begin
        #(200 * 40000);
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_free_run();
        test_hmove();
        test_wsync();
        test_rsync();
        test_phase_err_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_tia_horizontal_sync_ctl
`default_nettype wire
